// File: rtl/artyz7_button_input_if.sv
// artyz7_button_input_if: raw button pins in; debounced levels, pulses and toggles out.
interface artyz7_button_input_if #(parameter int num_buttons = 2);
  logic [num_buttons-1:0] button_raw, button_level, button_press, button_release, toggle_state;
  modport master(output button_raw, input button_level, button_press, button_release, toggle_state);
  modport slave(input button_raw, output button_level, button_press, button_release, toggle_state);
endinterface

// File: rtl/artyz7_button_input.sv
// artyz7_button_input: synchronize and debounce button pins; emit levels, press/release pulses and press toggles.
module artyz7_button_input #(
  parameter int num_buttons = 2,
  parameter int stable_cycles = 1000000,
  parameter logic [num_buttons-1:0] toggle_init = '0
) (
  input logic ext_clk,
  input logic reset,
  artyz7_button_input_if.slave btn
);
  localparam int cw = $clog2(stable_cycles + 1);
  localparam logic [cw-1:0] limit = cw'(stable_cycles);
  if (num_buttons < 1 || num_buttons > 8) begin : g_bad_num
    $error("num_buttons must be in 1..8");
  end
  if (stable_cycles < 1 || stable_cycles > (1 << 24)) begin : g_bad_stable
    $error("stable_cycles must be in 1..2^24");
  end
  typedef enum logic [1:0] {STABLE_LOW, PENDING_HIGH, STABLE_HIGH, PENDING_LOW} state_t;
  logic [num_buttons-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [num_buttons-1:0] level_q, level_d, press_q, press_d, release_q, release_d, toggle_q, toggle_d;
  state_t state_q [num_buttons];
  state_t state_d [num_buttons];
  logic [cw-1:0] cnt_q [num_buttons];
  logic [cw-1:0] cnt_d [num_buttons];
  always_comb begin
    sync1_d = btn.button_raw;
    sync2_d = sync1_q;
    for (int n = 0; n < num_buttons; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n] = '0;
      case (state_q[n])
        STABLE_LOW:
          if (sync2_q[n]) begin
            state_d[n] = PENDING_HIGH;
            cnt_d[n] = cw'(1);
          end
        PENDING_HIGH:
          if (!sync2_q[n]) state_d[n] = STABLE_LOW;
          else if (cnt_q[n] == limit) state_d[n] = STABLE_HIGH;
          else cnt_d[n] = cnt_q[n] + 1'b1;
        STABLE_HIGH:
          if (!sync2_q[n]) begin
            state_d[n] = PENDING_LOW;
            cnt_d[n] = cw'(1);
          end
        PENDING_LOW:
          if (sync2_q[n]) state_d[n] = STABLE_HIGH;
          else if (cnt_q[n] == limit) state_d[n] = STABLE_LOW;
          else cnt_d[n] = cnt_q[n] + 1'b1;
        default: state_d[n] = STABLE_LOW;
      endcase
      level_d[n] = state_d[n] == STABLE_HIGH || state_d[n] == PENDING_LOW;
    end
    press_d = level_d & ~level_q;
    release_d = ~level_d & level_q;
    toggle_d = toggle_q ^ press_d;
  end
  always_ff @(posedge ext_clk or posedge reset)
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      release_q <= '0;
      toggle_q <= toggle_init;
      for (int n = 0; n < num_buttons; n++) begin
        state_q[n] <= STABLE_LOW;
        cnt_q[n] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
      toggle_q <= toggle_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  assign btn.button_level = level_q;
  assign btn.button_press = press_q;
  assign btn.button_release = release_q;
  assign btn.toggle_state = toggle_q;
endmodule
